// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the stage-2 I/O request port between the CPU core
// and an auxiliary master (debug loader / DMA). The core has fixed priority.
// The aux master takes idle slots, or a forced slot (core stalled for one
// cycle) once it has been starved for MAX_WAIT cycles. Stage-3 read data is
// routed back to the aux master using a one-cycle ownership tag. The slot
// after an aux write is never granted to aux (read-after-write gap).

module io_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        reset,

    // Core stage-2 request
    input  logic [15:0] core_addr,
    input  logic [15:0] core_wdata,
    input  logic        core_read_req,
    input  logic        core_write_req,
    output logic        core_stall,
    output logic [15:0] core_rdata,

    // Auxiliary master
    input  logic        aux_req,
    input  logic [15:0] aux_addr,
    input  logic [15:0] aux_wdata,
    input  logic        aux_write,
    output logic        aux_grant,
    output logic        aux_rvalid,
    output logic [15:0] aux_rdata,

    // I/O controller
    output logic [15:0] io_addr,
    output logic [15:0] io_wdata,
    output logic        io_read_req,
    output logic        io_write_req,
    input  logic [15:0] io_rdata
);

    localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WaitOne = WAIT_W'(1);

    // Starvation counter and stage-3 ownership tags
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              aux_rd_q, aux_rd_d;
    logic              aux_wr_last_q, aux_wr_last_d;

    logic core_active;
    logic force_slot;
    logic aux_block;
    logic aux_go;

    assign core_active = core_read_req | core_write_req;
    assign force_slot  = (wait_cnt_q == WaitMax);
    // Slot right after a granted aux write is closed to aux, even when forced.
    assign aux_block   = aux_wr_last_q;

    // Grant decision: suppressed while the clock is disabled or in reset, so the
    // core always passes through in those cycles.
    assign aux_go = clk_en & ~reset & aux_req & ~aux_block & (~core_active | force_slot);

    assign aux_grant  = aux_go;
    assign core_stall = aux_go & core_active;

    // Stage-2 request mux: aux when granted, otherwise the (ungated) core
    always_comb begin
        io_addr      = core_addr;
        io_wdata     = core_wdata;
        io_read_req  = 1'b0;
        io_write_req = 1'b0;
        if (aux_go) begin
            io_addr      = aux_addr;
            io_wdata     = aux_wdata;
            io_read_req  = ~aux_write;
            io_write_req = aux_write;
        end else begin
            // core_stall is 0 here, so the core request goes through as-is.
            io_read_req  = core_read_req;
            io_write_req = core_write_req;
        end
    end

    // Stage-3 read-data routing; a pending tag is discarded by reset.
    assign aux_rvalid = aux_rd_q & clk_en & ~reset;
    assign aux_rdata  = io_rdata;
    assign core_rdata = io_rdata;

    // Next-state for starvation counter and ownership tags
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        aux_rd_d      = aux_go & ~aux_write;
        aux_wr_last_d = aux_go & aux_write;
        if (!aux_req || aux_go) begin
            wait_cnt_d = '0;
        end else if (aux_block) begin
            // Cycles lost to the read-after-write gap are not starvation.
            wait_cnt_d = wait_cnt_q;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WaitOne;
        end
    end

    // State registers: advance only on clk_en, synchronous reset
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                wait_cnt_q    <= '0;
                aux_rd_q      <= 1'b0;
                aux_wr_last_q <= 1'b0;
            end else begin
                wait_cnt_q    <= wait_cnt_d;
                aux_rd_q      <= aux_rd_d;
                aux_wr_last_q <= aux_wr_last_d;
            end
        end
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single stage-2 I/O request port of the I/O controller between two masters: the CPU core and an auxiliary master such as a debug loader or DMA.
- The core has fixed priority. The auxiliary master gets idle slots, plus a forced slot (core stalled one cycle) after MAX_WAIT starved cycles.
- The arbiter tags each granted access and routes the stage-3 read data back to the owning master.
- It also enforces the one-slot read-after-write gap for auxiliary accesses.

Parameters:
- MAX_WAIT, 15: starved aux-request cycles before a forced aux slot; legal range 1..255.
- WAIT_W, $clog2(MAX_WAIT+1): width of the starvation counter.

Ports:
- clk, input, 1: system clock.
- clk_en, input, 1: global clock enable; all state advances only when it is high.
- reset, input, 1: synchronous, active-high; sampled only when clk_en is high.
- core_addr, input, 16: core stage-2 I/O address.
- core_wdata, input, 16: core write data.
- core_read_req, input, 1: core I/O load.
- core_write_req, input, 1: core I/O store.
- core_stall, output, 1: core must hold its I/O request this cycle.
- core_rdata, output, 16: stage-3 read data to the core.
- aux_req, input, 1: aux master requests a slot; held until granted.
- aux_addr, input, 16: aux address.
- aux_wdata, input, 16: aux write data.
- aux_write, input, 1: 1 = write, 0 = read; valid with aux_req.
- aux_grant, output, 1: aux access issued this cycle.
- aux_rvalid, output, 1: aux read data valid this cycle.
- aux_rdata, output, 16: aux read data.
- io_addr, output, 16: to the I/O controller.
- io_wdata, output, 16: to the I/O controller.
- io_read_req, output, 1: to the I/O controller.
- io_write_req, output, 1: to the I/O controller.
- io_rdata, input, 16: stage-3 read data from the I/O controller.

Behaviour:
- core_active = core_read_req | core_write_req.
- force = (wait_cnt == MAX_WAIT).
- aux_block = aux_wr_last, a register that is 1 in the cycle after a granted aux write.
- aux_grant = clk_en & aux_req & ~aux_block & (~core_active | force). Combinational.
- core_stall = aux_grant & core_active. Combinational.
  - The stalled core access is not forwarded.
  - The core re-presents the request next cycle.
- Stage-2 mux, combinational:
  - When aux_grant: io_addr = aux_addr, io_wdata = aux_wdata, io_read_req = ~aux_write, io_write_req = aux_write.
  - Otherwise the core signals pass through unchanged, gated by ~core_stall.
  - With no requester active, io_read_req = io_write_req = 0 and addr/wdata follow the core.
- Starvation counter, updated on clk_en:
  - Clears to 0 when aux_req = 0 or aux_grant = 1.
  - Increments when aux_req & ~aux_grant.
  - Saturates at MAX_WAIT.
  - A blocked cycle (aux_block) does not count.
- Stage-3 tag registers, updated on clk_en:
  - aux_rd_reg <= aux_grant & ~aux_write.
  - aux_wr_last <= aux_grant & aux_write.
- Read-data routing:
  - aux_rvalid = aux_rd_reg & clk_en.
  - aux_rdata = io_rdata.
  - core_rdata = io_rdata, combinational pass-through. The core consumes it only for its own loads, and an aux-owned slot never carries a core load.
- Latency: aux read data arrives exactly 1 enabled cycle after aux_grant. The core path adds zero latency.
- Read-after-write gap: the cycle after any granted aux write, the aux master cannot be granted, even if force = 1. That slot goes to the core or stays idle.
- clk_en = 0:
  - All registers hold.
  - aux_grant = 0 and aux_rvalid = 0.
  - core_stall = 0.
  - The io_* outputs still mux the core's signals.
- Reset (synchronous, with clk_en = 1):
  - wait_cnt = 0, aux_rd_reg = 0, aux_wr_last = 0.
  - While reset is high: aux_grant = 0 and core_stall = 0, and the core signals pass through.
  - A read granted in the cycle before reset produces no aux_rvalid.
- aux_req dropped before grant: the counter clears and no access is issued.
- Core and aux both active with force = 0: the core wins and aux waits.

Test Plan:
1. Core idle, aux read to 0xFFF0 -> aux_grant in cycle N; io_read_req = 1 and io_addr = 0xFFF0 in N; aux_rvalid = 1 in N+1 with aux_rdata equal to io_rdata driven as 0x1234.
2. Core issues back-to-back loads every cycle, aux_req held, MAX_WAIT = 15 -> aux_grant = 0 for 15 cycles; on cycle 16 aux_grant = 1 and core_stall = 1; next cycle the core load is forwarded; wait_cnt = 0.
3. Aux write 0xABCD to 0xFFE0 then an immediate aux read -> write granted in N; no aux grant in N+1 (core_stall = 0); read granted in N+2.
4. clk_en toggled low mid-read (grant in N, clk_en = 0 in N+1) -> aux_rvalid = 0 in N+1; aux_rvalid = 1 in the first cycle clk_en returns high.
5. Reset asserted in the cycle after an aux read grant -> no aux_rvalid; wait_cnt = 0; aux_grant = 0 and core_stall = 0 while reset is high.
6. Core store and aux_req simultaneous with wait_cnt = 3 -> core store forwarded (io_write_req = 1, core_wdata on io_wdata); wait_cnt = 4; aux_grant = 0.
